cordic_rotate_seq: RTL and testbench

//  Iterative CORDIC rotation-mode engine. It applies a stored sequence of micro-rotation

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_gain_comp.sv | 32 +++
 rtl/cordic_rotate_seq.sv | 148 ++++++++++++++
 tb/tb_cordic_rotate_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, FSM state type and gain-compensation table for the CORDIC stages
// Purpose: common definitions imported by cordic_rotate_seq and cordic_gain_comp.
// Ports: none (package).
package cordic_pkg;

  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_FRAC       = 16;
  localparam int DEF_ITER       = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // K ~= 1/2 + 1/8 - 1/64 - 1/512 = 0.607421875 (ideal 1/1.64676 = 0.60725)
  localparam int GAIN_TERMS = 4;
  localparam logic [GAIN_TERMS-1:0][3:0] GAIN_SHIFT = {4'd9, 4'd6, 4'd3, 4'd1};
  // bit k set: term k is subtracted
  localparam logic [GAIN_TERMS-1:0] GAIN_SUB = 4'b1100;

endpackage

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - combinational shift-add CORDIC gain compensation with optional ones' complement
// Purpose: v' = (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9), then optionally inverted.
// Ports:
//   i_v    in  DATA_WIDTH  signed value to scale
//   i_neg  in  1           1: ones'-complement the scaled value
//   o_v    out DATA_WIDTH  scaled (and optionally inverted) value, wraps on overflow
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] i_v,
  input  logic                         i_neg,
  output logic signed [DATA_WIDTH-1:0] o_v
);

  logic signed [DATA_WIDTH-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < GAIN_TERMS; k++) begin
      if (GAIN_SUB[k]) begin
        w_acc = w_acc - (i_v >>> GAIN_SHIFT[k]);
      end else begin
        w_acc = w_acc + (i_v >>> GAIN_SHIFT[k]);
      end
    end
  end

  assign o_v = i_neg ? ~w_acc : w_acc;

endmodule

// File: rtl/cordic_rotate_seq.sv
// rtl/cordic_rotate_seq.sv - iterative CORDIC rotation engine replaying a stored direction word
// Purpose: rotates (x,y) by ITER micro-rotations chosen by in_dir, then gain-compensates.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake; in_ready high only when idle
//   in_x, in_y          signed input pair
//   in_dir              dir[i]=1 clockwise step i, 0 counter-clockwise
//   in_neg              1: ones'-complement both outputs after scaling
//   out_valid/out_ready result handshake; result held until accepted
//   out_x, out_y        rotated, scaled result (kept after handshake)
module cordic_rotate_seq
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC       = DEF_FRAC,
  parameter int ITER       = DEF_ITER
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  input  logic        [ITER-1:0]       in_dir,
  input  logic                         in_neg,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_x,
  output logic signed [DATA_WIDTH-1:0] out_y
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  // Shifts beyond the data width would only replicate sign bits.
  if (ITER > DATA_WIDTH - 1) begin : g_bad_iter
    $error("ITER must be <= DATA_WIDTH-1");
  end
  if (FRAC >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC must be < DATA_WIDTH");
  end

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CNT_W-1:0]             r_cnt;
  logic signed [DATA_WIDTH-1:0] r_x;
  logic signed [DATA_WIDTH-1:0] r_y;
  logic [ITER-1:0]              r_dir;
  logic                         r_neg;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_x;
  logic signed [DATA_WIDTH-1:0] r_out_y;
  logic signed [DATA_WIDTH-1:0] w_x_sh;
  logic signed [DATA_WIDTH-1:0] w_y_sh;
  logic signed [DATA_WIDTH-1:0] w_x_rot;
  logic signed [DATA_WIDTH-1:0] w_y_rot;
  logic signed [DATA_WIDTH-1:0] w_x_gain;
  logic signed [DATA_WIDTH-1:0] w_y_gain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = ROT;
      ROT:     if (r_cnt == LAST_CNT) w_state_next = SCALE;
      SCALE:   w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Barrel shift by the iteration index; direction bit picks add vs subtract.
  assign w_x_sh = r_x >>> r_cnt;
  assign w_y_sh = r_y >>> r_cnt;

  always_comb begin
    w_x_rot = r_x - w_y_sh;
    w_y_rot = r_y + w_x_sh;
    if (r_dir[r_cnt]) begin
      w_x_rot = r_x + w_y_sh;
      w_y_rot = r_y - w_x_sh;
    end
  end

  cordic_gain_comp #(.DATA_WIDTH(DATA_WIDTH)) u_gain_x (
    .i_v   (r_x),
    .i_neg (r_neg),
    .o_v   (w_x_gain)
  );

  cordic_gain_comp #(.DATA_WIDTH(DATA_WIDTH)) u_gain_y (
    .i_v   (r_y),
    .i_neg (r_neg),
    .o_v   (w_y_gain)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dir       <= '0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= in_x;
            r_y   <= in_y;
            r_dir <= in_dir;
            r_neg <= in_neg;
            r_cnt <= '0;
          end
        end
        ROT: begin
          r_x   <= w_x_rot;
          r_y   <= w_y_rot;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        SCALE: begin
          r_out_x     <= w_x_gain;
          r_out_y     <= w_y_gain;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// tb/tb_cordic_rotate_seq.sv - randomized scoreboard bench for cordic_rotate_seq
module tb_cordic_rotate_seq;

  localparam int DW  = 20;
  localparam int IT  = 12;
  localparam int LAT = IT + 1;   // clock edges from the accept edge until out_valid is seen
  localparam real KSH = 0.607421875;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic [IT-1:0] in_dir = '0;
  logic          in_neg = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_x;
  logic [DW-1:0] out_y;

  int vectors = 0;
  int miscompares = 0;

  logic [2*DW-1:0] exp_q[$];
  logic            busy = 1'b0;
  int              age = 0;
  logic            checking = 1'b0;
  logic [DW-1:0]   mx, my;

  always #5 clk = ~clk;

  cordic_rotate_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_dir    (in_dir),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input longint act, input real req);
    real d;
    vectors++;
    d = real'(act) - req;
    if (d > 8.0 || d < -8.0) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %f (+-8)", name, act, req);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] b);
    logic signed [DW-1:0] s;
    s = b;
    return longint'(s);
  endfunction

  // floor(v / 2^sh) by plain division
  function automatic longint fdiv(input longint v, input int sh);
    longint p, q;
    p = longint'(1) << sh;
    q = v / p;
    if ((v % p != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint wrapv(input longint v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    return sx(b);
  endfunction

  function automatic void model(input logic [DW-1:0] xi, input logic [DW-1:0] yi,
                                input logic [IT-1:0] d, input logic n,
                                output logic [DW-1:0] xo, output logic [DW-1:0] yo);
    longint x, y, nx, ny;
    x = sx(xi);
    y = sx(yi);
    for (int i = 0; i < IT; i++) begin
      if (d[i]) begin
        nx = x + fdiv(y, i);
        ny = y - fdiv(x, i);
      end else begin
        nx = x - fdiv(y, i);
        ny = y + fdiv(x, i);
      end
      x = wrapv(nx);
      y = wrapv(ny);
    end
    x = wrapv(fdiv(x, 1) + fdiv(x, 3) - fdiv(x, 6) - fdiv(x, 9));
    y = wrapv(fdiv(y, 1) + fdiv(y, 3) - fdiv(y, 6) - fdiv(y, 9));
    xo = x[DW-1:0];
    yo = y[DW-1:0];
    if (n) begin
      xo = ~xo;
      yo = ~yo;
    end
  endfunction

  // Ideal rotation by the signed sum of atan(2^-i), with the CORDIC growth and the shift-add gain.
  function automatic void float_ref(input longint x, input longint y, input logic [IT-1:0] d,
                                    output real fx, output real fy);
    real th, a, p;
    th = 0.0;
    a  = 1.0;
    p  = 1.0;
    for (int i = 0; i < IT; i++) begin
      a  = a * $sqrt(1.0 + p * p);
      th = d[i] ? th - $atan(p) : th + $atan(p);
      p  = p * 0.5;
    end
    fx = KSH * a * (real'(x) * $cos(th) - real'(y) * $sin(th));
    fy = KSH * a * (real'(x) * $sin(th) + real'(y) * $cos(th));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      age  <= 0;
      exp_q.delete();
    end else begin
      if (busy) age <= age + 1;
      if (in_valid && in_ready) begin
        model(in_x, in_y, in_dir, in_neg, mx, my);
        exp_q.push_back({mx, my});
        busy <= 1'b1;
        age  <= 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      check("in_ready", longint'(in_ready), longint'(!busy));
      check("out_valid", longint'(out_valid), longint'(busy && age >= LAT));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("result_pending", longint'(exp_q.size()), 1);
        end else begin
          check("out_x", longint'(out_x), longint'(exp_q[0][2*DW-1:DW]));
          check("out_y", longint'(out_y), longint'(exp_q[0][DW-1:0]));
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [IT-1:0] d, input logic n);
    int w;
    @(negedge clk);
    in_x = x; in_y = y; in_dir = d; in_neg = n; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("accept_timeout", w, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("post_valid", longint'(out_valid), 0);
    check("post_ready", longint'(in_ready), 1);
  endtask

  initial begin
    int lat, n;
    logic [DW-1:0] sx_hold, sy_hold;
    real fx, fy;

    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_x", longint'(out_x), 0);
    check("rst_out_y", longint'(out_y), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checking = 1'b1;

    // hand-computed pins of the model
    model(20'd65536, 20'd0, 12'h000, 1'b0, mx, my);
    check("pin_x_dir0", longint'(mx), longint'(20'hFD42F));
    check("pin_y_dir0", longint'(my), longint'(20'h0FC49));
    model(20'd0, 20'd0, 12'h000, 1'b1, mx, my);
    check("pin_x_zero_neg", longint'(mx), longint'(20'hFFFFF));
    check("pin_y_zero_neg", longint'(my), longint'(20'hFFFFF));

    // zero input with ones'-complement
    send(20'd0, 20'd0, 12'h000, 1'b1);
    wait_valid(lat);
    check("lat_zero", lat, LAT);
    check("zero_x", longint'(out_x), longint'(20'hFFFFF));
    check("zero_y", longint'(out_y), longint'(20'hFFFFF));
    consume(0);

    // all counter-clockwise
    send(20'd65536, 20'd0, 12'h000, 1'b0);
    wait_valid(lat);
    check("lat_dir0", lat, LAT);
    float_ref(65536, 0, 12'h000, fx, fy);
    check_near("float_x_dir0", sx(out_x), fx);
    check_near("float_y_dir0", sx(out_y), fy);
    consume(1);

    // +45 then clockwise
    send(20'd65536, 20'd0, 12'hFFE, 1'b0);
    wait_valid(lat);
    float_ref(65536, 0, 12'hFFE, fx, fy);
    check_near("float_x_dirFFE", sx(out_x), fx);
    check_near("float_y_dirFFE", sx(out_y), fy);
    consume(0);

    // backpressure with a competing input
    send(20'h0A123, 20'hF3456, 12'h5A5, 1'b0);
    wait_valid(lat);
    sx_hold = out_x;
    sy_hold = out_y;
    @(negedge clk);
    in_x = 20'h01234; in_y = 20'h04321; in_dir = 12'h0F0; in_neg = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_hold_x", longint'(out_x), longint'(sx_hold));
      check("bp_hold_y", longint'(out_y), longint'(sy_hold));
      check("bp_in_ready", longint'(in_ready), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_ready", longint'(in_ready), 1);
    check("bp_release_valid", longint'(out_valid), 0);
    check("bp_keep_x", longint'(out_x), longint'(sx_hold));
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_accept_next", longint'(in_ready), 0);
    wait_valid(lat);
    check("lat_bp", lat, LAT);
    consume(2);

    // reset in the middle of the rotation (cnt==5)
    send(20'h12345, 20'h00777, 12'h3C3, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", longint'(in_ready), 1);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_x", longint'(out_x), 0);
    check("mid_rst_out_y", longint'(out_y), 0);
    @(negedge clk) rst = 1'b0;
    send(20'h20000, 20'hE0000, 12'h8C1, 1'b1);
    wait_valid(lat);
    check("lat_after_rst", lat, LAT);
    consume(0);

    // randomized traffic with junk inputs and stray out_ready while busy
    for (int t = 0; t < 25; t++) begin
      send(DW'($urandom), DW'($urandom), IT'($urandom), 1'($urandom_range(0, 1)));
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        in_x      = DW'($urandom);
        @(posedge clk);
        #1 n++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("rand_lat", n, LAT);
      consume($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
    $fatal(1);
  end

endmodule
